// File: rtl/conv_sequencer.sv
// conv_sequencer: single-FSM scheduler that loads x/f memories, sequences MAC reads and streams each 1-D convolution output
module conv_sequencer #(
  parameter int LENX   = 8,
  parameter int LENF   = 4,
  parameter int ADDR_X = 3,
  parameter int ADDR_F = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid_x,
  output logic              s_ready_x,
  input  logic              s_valid_f,
  output logic              s_ready_f,
  output logic [ADDR_X-1:0] addr_x,
  output logic              wr_en_x,
  output logic [ADDR_F-1:0] addr_f,
  output logic              wr_en_f,
  output logic              en_acc,
  output logic              clr_acc,
  output logic              m_valid_y,
  input  logic              m_ready_y,
  output logic              y_last,
  output logic              frame_done
);
  localparam int NOUT = LENX - LENF + 1;
  localparam int TW = LENF > 1 ? $clog2(LENF) : 1;
  localparam int OW = NOUT > 1 ? $clog2(NOUT) : 1;
  localparam int XL = LENX - 1;
  localparam int FL = LENF - 1;
  localparam int OL = NOUT - 1;
  localparam logic [ADDR_X:0] X_END = LENX[ADDR_X:0];
  localparam logic [ADDR_X:0] X_LAST = XL[ADDR_X:0];
  localparam logic [ADDR_F:0] F_END = LENF[ADDR_F:0];
  localparam logic [ADDR_F:0] F_LAST = FL[ADDR_F:0];
  localparam logic [TW-1:0] T_END = FL[TW-1:0];
  localparam logic [OW-1:0] O_END = OL[OW-1:0];
  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN, OUTPUT} state_t;
  state_t state, state_nx;
  logic [ADDR_X:0] x_cnt;
  logic [ADDR_F:0] f_cnt;
  logic [TW-1:0] tap;
  logic [OW-1:0] out_idx;
  logic x_full, f_full, y_hs;
  // a write landing on this edge counts as complete, so COMPUTE follows the last write directly
  assign x_full = x_cnt == X_END || (wr_en_x && x_cnt == X_LAST);
  assign f_full = f_cnt == F_END || (wr_en_f && f_cnt == F_LAST);
  assign y_hs = m_valid_y && m_ready_y;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= LOAD;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = x_full && f_full ? COMPUTE : LOAD;
      COMPUTE: state_nx = tap == T_END ? DRAIN : COMPUTE;
      DRAIN:   state_nx = OUTPUT;
      default: state_nx = m_ready_y ? (y_last ? LOAD : COMPUTE) : OUTPUT;
    endcase
  end
  // outside LOAD the tap saturates at its last value, so addresses hold through DRAIN/OUTPUT
  always_comb begin
    s_ready_x = state == LOAD && x_cnt != X_END && !reset;
    s_ready_f = state == LOAD && f_cnt != F_END && !reset;
    wr_en_x = s_valid_x && s_ready_x;
    wr_en_f = s_valid_f && s_ready_f;
    addr_x = state == LOAD ? x_cnt[ADDR_X-1:0] : ADDR_X'(out_idx) + ADDR_X'(tap);
    addr_f = state == LOAD ? f_cnt[ADDR_F-1:0] : ADDR_F'(tap);
    m_valid_y = state == OUTPUT;
    y_last = m_valid_y && out_idx == O_END;
    clr_acc = state == LOAD || (m_valid_y && m_ready_y);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x_cnt <= '0;
      f_cnt <= '0;
      tap <= '0;
      out_idx <= '0;
      en_acc <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      en_acc <= state == COMPUTE;
      frame_done <= y_hs && y_last;
      if (wr_en_x) x_cnt <= x_cnt + 1'b1;
      if (wr_en_f) f_cnt <= f_cnt + 1'b1;
      if (state == COMPUTE && tap != T_END) tap <= tap + 1'b1;
      if (y_hs) begin
        tap <= '0;
        out_idx <= y_last ? '0 : out_idx + 1'b1;
        if (y_last) begin
          x_cnt <= '0;
          f_cnt <= '0;
        end
      end
    end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: scoreboard bench with behavioural x/f memories and MAC accumulator around conv_sequencer
module tb_conv_sequencer;
  localparam int LENX = 8, LENF = 4, NOUT = LENX - LENF + 1, SP = LENF + 2;
  logic clk = 1'b0, reset = 1'b1;
  logic s_valid_x = 1'b0, s_valid_f = 1'b0, m_ready_y = 1'b1;
  logic s_ready_x, s_ready_f, wr_en_x, wr_en_f, en_acc, clr_acc, m_valid_y, y_last, frame_done;
  logic [2:0] addr_x;
  logic [1:0] addr_f;
  int x_data, f_data, acc, rdx, rdf, cyc;
  int xm[LENX];
  int fm[LENF];
  int sb[$], got[$], hs[$], lg_addr[$], lg_acc[$];
  bit yl[$], lg_en[$], lg_clr[$], lg_fd[$], lg_rdyx[$], lg_rdyf[$], lg_wrx[$], lg_stall[$];
  int n_cmp = 0, n_err = 0, base, lw, stalled, ign_bad, ign_seen;
  bit fd_first, wr_first;

  conv_sequencer #(.LENX(LENX), .LENF(LENF), .ADDR_X(3), .ADDR_F(2)) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .addr_x(addr_x), .wr_en_x(wr_en_x), .addr_f(addr_f), .wr_en_f(wr_en_f),
    .en_acc(en_acc), .clr_acc(clr_acc),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y), .y_last(y_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // external memories with one-cycle read latency feeding a MAC accumulator
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_x) xm[addr_x] <= x_data;
    if (wr_en_f) fm[addr_f] <= f_data;
    rdx <= xm[addr_x];
    rdf <= fm[addr_f];
    acc <= clr_acc ? 0 : en_acc ? acc + rdx * rdf : acc;
  end

  task automatic load(input int xs[LENX], input int fs[LENF], input int xgap, input int fgap, input bit extra);
    int xi = 0, fi = 0, xw = 0, fw = 0, c = 0;
    for (int o = 0; o < NOUT; o++) begin
      int s;
      s = 0;
      for (int t = 0; t < LENF; t++) s += xs[o+t] * fs[t];
      sb.push_back(s);
    end
    ign_bad = 0;
    ign_seen = 0;
    while ((xi < LENX || fi < LENF) && c < 200) begin
      @(negedge clk);
      s_valid_x = xi < LENX ? xw == 0 : extra;
      s_valid_f = fi < LENF && fw == 0;
      x_data = xs[xi < LENX ? xi : 0];
      f_data = fs[fi < LENF ? fi : 0];
      #1;
      if (c == 0) begin fd_first = frame_done; wr_first = wr_en_x; end
      if (xi == LENX && s_valid_x) begin ign_seen++; if (s_ready_x || wr_en_x) ign_bad++; end
      if (wr_en_x) begin xi++; xw = xgap; end else if (xw > 0) xw--;
      if (wr_en_f) begin fi++; fw = fgap; end else if (fw > 0) fw--;
      lw = cyc;
      c++;
    end
    if (xi < LENX || fi < LENF) begin
      n_cmp++; n_err++;
      $display("FAIL load_timeout got x=%0d f=%0d writes, want %0d/%0d", xi, fi, LENX, LENF);
    end
  endtask

  task automatic run_outputs(input int n_out, input int stall_k, input int stall_n, input int post, input bit keep_x);
    int k = 0, p = 0, c = 0;
    got.delete(); yl.delete(); hs.delete();
    lg_addr.delete(); lg_acc.delete(); lg_en.delete(); lg_clr.delete(); lg_fd.delete();
    lg_rdyx.delete(); lg_rdyf.delete(); lg_wrx.delete(); lg_stall.delete();
    stalled = 0;
    while (c < 400 && !(k == n_out && p == post)) begin
      @(negedge clk);
      s_valid_f = 1'b0;
      s_valid_x = keep_x;
      m_ready_y = !(k == stall_k && stalled < stall_n);
      #1;
      if (c == 0) base = cyc;
      lg_addr.push_back(addr_x); lg_acc.push_back(acc); lg_en.push_back(en_acc); lg_clr.push_back(clr_acc);
      lg_fd.push_back(frame_done); lg_rdyx.push_back(s_ready_x); lg_rdyf.push_back(s_ready_f);
      lg_wrx.push_back(wr_en_x); lg_stall.push_back(m_valid_y && !m_ready_y);
      if (m_valid_y && !m_ready_y) stalled++;
      if (k == n_out) p++;
      else if (m_valid_y && m_ready_y) begin got.push_back(acc); yl.push_back(y_last); hs.push_back(cyc); k++; end
      c++;
    end
    if (k < n_out) begin
      n_cmp++; n_err++;
      $display("FAIL output_timeout got %0d outputs, want %0d", k, n_out);
    end
  endtask

  task automatic test_reset;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (s_ready_x !== 1'b0) begin n_err++; $display("FAIL rst_async_ready_x got=%0b want=0", s_ready_x); end
    n_cmp++; if (clr_acc !== 1'b1) begin n_err++; $display("FAIL rst_async_clr got=%0b want=1", clr_acc); end
    n_cmp++; if (m_valid_y !== 1'b0) begin n_err++; $display("FAIL rst_async_valid got=%0b want=0", m_valid_y); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_ready_f !== 1'b0) begin n_err++; $display("FAIL rst_ready_f got=%0b want=0", s_ready_f); end
    n_cmp++; if (en_acc !== 1'b0) begin n_err++; $display("FAIL rst_en_acc got=%0b want=0", en_acc); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got=%0b want=0", frame_done); end
    n_cmp++; if (addr_x !== 3'd0 || addr_f !== 2'd0) begin n_err++; $display("FAIL rst_addr got=%0d/%0d want=0/0", addr_x, addr_f); end
    n_cmp++; if (y_last !== 1'b0) begin n_err++; $display("FAIL rst_y_last got=%0b want=0", y_last); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (s_ready_x !== 1'b1 || s_ready_f !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%0b%0b want=11", s_ready_x, s_ready_f); end
  endtask

  task automatic test_nominal;
    int xs[LENX];
    int fs[LENF];
    int fdn = 0;
    int e, h;
    xs = '{1, 2, 3, 4, 5, 6, 7, 8};
    fs = '{1, 1, 1, 1};
    load(xs, fs, 0, 0, 1'b0);
    run_outputs(NOUT, -1, 0, 2, 1'b0);
    for (int k = 0; k < got.size(); k++) begin
      e = sb.pop_front();
      n_cmp++; if (got[k] !== e) begin n_err++; $display("FAIL nom_y%0d got=%0d want=%0d", k, got[k], e); end
      n_cmp++; if (yl[k] !== (k == NOUT - 1)) begin n_err++; $display("FAIL nom_y_last%0d got=%0b want=%0b", k, yl[k], k == NOUT - 1); end
    end
    if (hs.size() == NOUT) begin
      n_cmp++; if (hs[0] - lw !== SP) begin n_err++; $display("FAIL nom_first_latency got=%0d want=%0d", hs[0] - lw, SP); end
      for (int k = 1; k < NOUT; k++) begin
        n_cmp++; if (hs[k] - hs[k-1] !== SP) begin n_err++; $display("FAIL nom_spacing%0d got=%0d want=%0d", k, hs[k] - hs[k-1], SP); end
      end
      for (int i = 0; i < LENF; i++) begin
        h = hs[1] + 1 + i - base;
        n_cmp++; if (lg_addr[h] !== 2 + i) begin n_err++; $display("FAIL nom_out2_addr%0d got=%0d want=%0d", i, lg_addr[h], 2 + i); end
      end
      h = hs[NOUT-1] + 1 - base;
      n_cmp++; if (lg_fd[h] !== 1'b1) begin n_err++; $display("FAIL nom_frame_done got=%0b want=1", lg_fd[h]); end
      n_cmp++; if (lg_rdyx[h] !== 1'b1 || lg_rdyf[h] !== 1'b1) begin n_err++; $display("FAIL nom_ready_at_done got=%0b%0b want=11", lg_rdyx[h], lg_rdyf[h]); end
      n_cmp++; if (lg_fd[h+1] !== 1'b0) begin n_err++; $display("FAIL nom_frame_done_width got=%0b want=0", lg_fd[h+1]); end
    end
    foreach (lg_fd[i]) fdn += lg_fd[i];
    n_cmp++; if (fdn !== 1) begin n_err++; $display("FAIL nom_frame_done_count got=%0d want=1", fdn); end
  endtask

  task automatic test_skew;
    int xs[LENX];
    int fs[LENF];
    int wb = 0;
    int e;
    foreach (xs[i]) xs[i] = $urandom_range(0, 15);
    foreach (fs[i]) fs[i] = $urandom_range(0, 15);
    load(xs, fs, 0, 3, 1'b1);
    n_cmp++; if (ign_bad !== 0) begin n_err++; $display("FAIL skew_extra_x_accepted got=%0d want=0 of %0d", ign_bad, ign_seen); end
    run_outputs(NOUT, -1, 0, 0, 1'b1);
    s_valid_x = 1'b0;
    foreach (lg_wrx[i]) wb += lg_wrx[i];
    n_cmp++; if (wb !== 0) begin n_err++; $display("FAIL skew_wr_outside_load got=%0d want=0", wb); end
    n_cmp++; if (lg_en[0] !== 1'b0 || lg_en[1] !== 1'b1) begin n_err++; $display("FAIL skew_en_acc_start got=%0b%0b want=01", lg_en[0], lg_en[1]); end
    if (hs.size() == NOUT) begin
      n_cmp++; if (hs[0] - lw !== SP) begin n_err++; $display("FAIL skew_first_latency got=%0d want=%0d", hs[0] - lw, SP); end
    end
    for (int k = 0; k < got.size(); k++) begin
      e = sb.pop_front();
      n_cmp++; if (got[k] !== e) begin n_err++; $display("FAIL skew_y%0d got=%0d want=%0d", k, got[k], e); end
    end
  endtask

  task automatic test_backpressure;
    int xs[LENX];
    int fs[LENF];
    int e, h;
    foreach (xs[i]) xs[i] = $urandom_range(0, 15);
    foreach (fs[i]) fs[i] = $urandom_range(0, 15);
    load(xs, fs, 0, 0, 1'b0);
    run_outputs(NOUT, 3, 7, 1, 1'b0);
    n_cmp++; if (stalled !== 7) begin n_err++; $display("FAIL bp_stall_cycles got=%0d want=7", stalled); end
    for (int k = 0; k < got.size(); k++) begin
      e = sb.pop_front();
      n_cmp++; if (got[k] !== e) begin n_err++; $display("FAIL bp_y%0d got=%0d want=%0d", k, got[k], e); end
    end
    if (hs.size() == NOUT) begin
      h = hs[3] - base;
      n_cmp++; if (lg_addr[h] !== 3 + LENF - 1) begin n_err++; $display("FAIL bp_addr_hold got=%0d want=%0d", lg_addr[h], 3 + LENF - 1); end
      for (int i = h - 7; i < h; i++) begin
        n_cmp++; if (lg_stall[i] !== 1'b1) begin n_err++; $display("FAIL bp_valid_held c%0d got=%0b want=1", i, lg_stall[i]); end
        n_cmp++; if (lg_en[i] !== 1'b0 || lg_clr[i] !== 1'b0) begin n_err++; $display("FAIL bp_acc_ctrl c%0d got en=%0b clr=%0b want 0/0", i, lg_en[i], lg_clr[i]); end
        n_cmp++; if (lg_acc[i] !== got[3] || lg_addr[i] !== lg_addr[h]) begin n_err++; $display("FAIL bp_stable c%0d got acc=%0d addr=%0d want %0d/%0d", i, lg_acc[i], lg_addr[i], got[3], lg_addr[h]); end
      end
      n_cmp++; if (hs[4] - hs[3] !== SP) begin n_err++; $display("FAIL bp_next_output got=%0d want=%0d", hs[4] - hs[3], SP); end
    end
  endtask

  task automatic test_reset_mid;
    int xs[LENX];
    int fs[LENF];
    int e;
    foreach (xs[i]) xs[i] = $urandom_range(0, 15);
    foreach (fs[i]) fs[i] = $urandom_range(0, 15);
    load(xs, fs, 0, 0, 1'b0);
    run_outputs(2, -1, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (m_valid_y !== 1'b0 || s_ready_x !== 1'b0) begin n_err++; $display("FAIL rmid_outputs got valid=%0b rdy=%0b want 0/0", m_valid_y, s_ready_x); end
    n_cmp++; if (clr_acc !== 1'b1 || addr_x !== 3'd0 || en_acc !== 1'b0) begin n_err++; $display("FAIL rmid_load got clr=%0b addr=%0d en=%0b want 1/0/0", clr_acc, addr_x, en_acc); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    #1;
    n_cmp++; if (s_ready_x !== 1'b1 || s_ready_f !== 1'b1) begin n_err++; $display("FAIL rmid_release_ready got=%0b%0b want=11", s_ready_x, s_ready_f); end
    xs = '{2, 3, 4, 5, 6, 7, 8, 9};
    fs = '{1, 0, 0, 1};
    load(xs, fs, 0, 0, 1'b0);
    run_outputs(NOUT, -1, 0, 1, 1'b0);
    for (int k = 0; k < got.size(); k++) begin
      e = sb.pop_front();
      n_cmp++; if (got[k] !== e) begin n_err++; $display("FAIL rmid_y%0d got=%0d want=%0d", k, got[k], e); end
    end
    if (hs.size() == NOUT) begin
      n_cmp++; if (hs[0] - lw !== SP) begin n_err++; $display("FAIL rmid_full_reload_latency got=%0d want=%0d", hs[0] - lw, SP); end
    end
  endtask

  task automatic test_back_to_back;
    int xa[LENX];
    int fa[LENF];
    int xb[LENX];
    int fb[LENF];
    int e;
    foreach (xa[i]) begin xa[i] = $urandom_range(0, 15); xb[i] = $urandom_range(0, 15); end
    foreach (fa[i]) begin fa[i] = $urandom_range(1, 15); fb[i] = $urandom_range(0, 15); end
    load(xa, fa, 0, 0, 1'b0);
    run_outputs(NOUT, -1, 0, 0, 1'b0);
    for (int k = 0; k < got.size(); k++) begin
      e = sb.pop_front();
      n_cmp++; if (got[k] !== e) begin n_err++; $display("FAIL b2b_a_y%0d got=%0d want=%0d", k, got[k], e); end
    end
    load(xb, fb, 0, 1, 1'b0);
    n_cmp++; if (fd_first !== 1'b1 || wr_first !== 1'b1) begin n_err++; $display("FAIL b2b_write_in_done_cycle got fd=%0b wr=%0b want 1/1", fd_first, wr_first); end
    run_outputs(NOUT, 0, 2, 1, 1'b0);
    for (int k = 0; k < got.size(); k++) begin
      e = sb.pop_front();
      n_cmp++; if (got[k] !== e) begin n_err++; $display("FAIL b2b_b_y%0d got=%0d want=%0d", k, got[k], e); end
      n_cmp++; if (yl[k] !== (k == NOUT - 1)) begin n_err++; $display("FAIL b2b_b_y_last%0d got=%0b want=%0b", k, yl[k], k == NOUT - 1); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_nominal;
    test_skew;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
